// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - op codes, FSM states and op classification for exec_unit
package exec_pkg;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU  = 5'd19;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  function automatic logic is_iter_op(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational single-cycle ALU; unknown op codes give 0
module alu_core
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b_i[SHW-1:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_SLL:  result_o = a_i << shamt;
      OP_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SRL:  result_o = a_i >> shamt;
      OP_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      OP_OR:   result_o = a_i | b_i;
      OP_AND:  result_o = a_i & b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - registered ALU plus iterative shift-add multiply / restoring divide
module exec_unit
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            res_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  logic [SHW:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic                neg_q, neg_d;
  logic [4:0]          op_q, op_d;
  logic                valid_q, valid_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic [XLEN-1:0]     alu_res;

  alu_core #(.XLEN(XLEN)) u_alu (
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .result_o (alu_res)
  );

  // Operand signedness and magnitudes for the op being offered
  logic            a_signed, b_signed, a_sgn, b_sgn, div_zero, div_ovf, accept;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  always_comb begin
    a_signed = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
               (op_i == OP_DIV) || (op_i == OP_REM);
    b_signed = (op_i == OP_MUL) || (op_i == OP_MULH) ||
               (op_i == OP_DIV) || (op_i == OP_REM);
    a_sgn    = a_signed && a_i[XLEN-1];
    b_sgn    = b_signed && b_i[XLEN-1];
    a_mag    = a_sgn ? ('0 - a_i) : a_i;
    b_mag    = b_sgn ? ('0 - b_i) : b_i;
    div_zero = (b_i == '0);
    div_ovf  = a_signed && b_signed && (a_i == MOST_NEG) && (b_i == '1);
    fast_res = '0;
    if (div_zero)
      fast_res = ((op_i == OP_DIV) || (op_i == OP_DIVU)) ? '1 : a_i;
    else if (div_ovf)
      fast_res = (op_i == OP_DIV) ? a_i : '0;
  end

  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  logic [XLEN-1:0]   mul_fin, div_pick, div_fin;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    // acc holds {remainder, dividend/quotient}; trial subtract on the shifted remainder
    div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, opb_q};
    div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    prod      = neg_q ? ('0 - mul_next) : mul_next;
    mul_fin   = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    div_pick  = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? div_next[XLEN-1:0]
                                                        : div_next[2*XLEN-1:XLEN];
    div_fin   = neg_q ? ('0 - div_pick) : div_pick;
  end

  assign ready_o  = (state_q == ST_IDLE) && (!valid_q || ready_i);
  assign accept   = valid_i && ready_o && !flush_i;
  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign busy_o   = (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    op_d     = op_q;
    valid_d  = valid_q;
    result_d = result_q;

    if (valid_q && ready_i)
      valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = op_i;
          if (is_iter_op(op_i) && !(is_div_op(op_i) && (div_zero || div_ovf))) begin
            state_d = is_div_op(op_i) ? ST_DIV : ST_MUL;
            cnt_d   = (SHW+1)'(XLEN);
            acc_d   = {{XLEN{1'b0}}, is_div_op(op_i) ? a_mag : b_mag};
            opb_d   = is_div_op(op_i) ? b_mag : a_mag;
            neg_d   = (op_i == OP_REM) ? a_sgn : (a_sgn ^ b_sgn);
          end else begin
            result_d = is_div_op(op_i) ? fast_res : alu_res;
            valid_d  = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == (SHW+1)'(1)) begin
          result_d = mul_fin;
          valid_d  = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == (SHW+1)'(1)) begin
          result_d = div_fin;
          valid_d  = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush_i) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      op_q     <= OP_ADD;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - directed checks of exec_unit with hand-computed results
module tb_exec_unit;
  import exec_pkg::*;

  logic        clk_i = 1'b0;
  logic        res_i;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  exec_unit #(.XLEN(32)) dut (
    .clk_i    (clk_i),
    .res_i    (res_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Called #1 after a rising edge; returns #1 after the accept edge
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    valid_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    #1;
    check("ready_before_accept", {31'b0, ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic single(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    issue(op, a, b);
    check({tag, "_valid"}, {31'b0, valid_o}, 32'd1);
    check(tag, result_o, exp);
  endtask

  task automatic iter(input string tag, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
    int n;
    bit bad;
    n   = 0;
    bad = 1'b0;
    issue(op, a, b);
    while (!valid_o && n < 40) begin
      if (!busy_o || ready_o) bad = 1'b1;
      @(posedge clk_i);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, 32'd32);
    check({tag, "_busy_not_ready"}, {31'b0, bad}, 32'd0);
    check(tag, result_o, exp);
  endtask

  initial begin
    bit ok_stable;
    bit saw_valid;
    res_i   = 1'b0;
    valid_i = 1'b0;
    op_i    = OP_ADD;
    a_i     = '0;
    b_i     = '0;
    flush_i = 1'b0;
    ready_i = 1'b1;

    #3;
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_ready", {31'b0, ready_o}, 32'd1);
    #9 res_i = 1'b1;
    @(posedge clk_i);
    #1;

    single("add", OP_ADD, 32'd7, 32'd5, 32'd12);
    single("sub", OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF);
    single("sra", OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
    single("srl", OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
    single("sll_mask", OP_SLL, 32'd1, 32'h0000_003F, 32'h8000_0000);
    single("sltu", OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1);
    single("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    single("illegal10", 5'd10, 32'd7, 32'd5, 32'd0);

    iter("mul", OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    iter("mulh", OP_MULH, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    iter("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001);
    iter("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    single("div_by0", OP_DIV, 32'd7, 32'd0, 32'hFFFF_FFFF);
    single("rem_by0", OP_REM, 32'd7, 32'd0, 32'd7);
    single("divu_by0", OP_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF);
    single("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    single("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    iter("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    iter("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    iter("div_negdiv", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    iter("rem_negdiv", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1);
    iter("divu", OP_DIVU, 32'd100, 32'd7, 32'd14);
    iter("remu", OP_REMU, 32'd100, 32'd7, 32'd2);

    // Backpressure: hold a result for 5 cycles, then consume and accept together
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    single("bp_add", OP_ADD, 32'd3, 32'd4, 32'd7);
    ok_stable = 1'b1;
    repeat (5) begin
      @(posedge clk_i);
      #1;
      if (result_o !== 32'd7 || valid_o !== 1'b1 || ready_o !== 1'b0) ok_stable = 1'b0;
    end
    check("bp_hold", {31'b0, ok_stable}, 32'd1);
    ready_i = 1'b1;
    single("bp_replace", OP_ADD, 32'd1, 32'd1, 32'd2);

    // Flush blocks acceptance in its own cycle
    @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    valid_i = 1'b1;
    op_i    = OP_ADD;
    a_i     = 32'd9;
    b_i     = 32'd9;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    check("flush_blocks_accept", {31'b0, valid_o}, 32'd0);

    // Flush during DIVU iteration 10
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk_i);
      #1;
    end
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    check("flush_valid", {31'b0, valid_o}, 32'd0);
    check("flush_ready", {31'b0, ready_o}, 32'd1);
    check("flush_busy", {31'b0, busy_o}, 32'd0);
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk_i);
      #1;
      if (valid_o) saw_valid = 1'b1;
    end
    check("flush_no_result", {31'b0, saw_valid}, 32'd0);

    // Asynchronous reset in the middle of a multiply
    issue(OP_MUL, 32'd3, 32'd5);
    repeat (5) begin
      @(posedge clk_i);
      #1;
    end
    check("mul_busy_pre_reset", {31'b0, busy_o}, 32'd1);
    #2 res_i = 1'b0;
    #1;
    check("areset_busy", {31'b0, busy_o}, 32'd0);
    check("areset_valid", {31'b0, valid_o}, 32'd0);
    check("areset_result", result_o, 32'd0);
    check("areset_ready", {31'b0, ready_o}, 32'd1);
    #2 res_i = 1'b1;
    @(posedge clk_i);
    #1;
    single("add_after_reset", OP_ADD, 32'd7, 32'd5, 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised execute unit for the RV32 core: a registered single-cycle ALU plus iterative multiply/divide (RV32M). Operands and an operation code come from the controller/register-file stage over a valid/ready handshake; results go to writeback over a second valid/ready handshake. XLEN, not 32, sets every datapath width.

## Interface

- `XLEN`, 32: operand/result width; must be a power of two, at least 8.
- `SHW`, $clog2(XLEN): shift-amount width, derived and not overridden.

- `clk_i`  in  1  clock; one clock domain.
- `res_i`  in  1  reset, asynchronous, active-low.
- `valid_i`  in  1  operation request.
- `ready_o`  out  1  unit can accept an operation this cycle.
- `op_i`  in  5  operation code (exec_pkg).
- `a_i`, `b_i`  in  XLEN  operands; shift amount is `b_i[SHW-1:0]`.
- `flush_i`  in  1  synchronous abort.
- `valid_o`  out  1  `result_o` holds an unconsumed result.
- `ready_i`  in  1  writeback consumes the result.
- `result_o`  out  XLEN  result register.
- `busy_o`  out  1  iterative operation in progress.

## Operation

- Op codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU. Any other code is illegal and completes in one cycle with result 0.
- Accept condition: `valid_i && ready_o`, where `ready_o = (state==IDLE) && (!valid_o || ready_i)`.
- States: IDLE, MUL, DIV.
  - IDLE → MUL on accepting ops 16–19.
  - IDLE → DIV on accepting ops 20–23, unless a fast path applies.
  - MUL/DIV → IDLE after the XLEN-th iteration.
  - Any state → IDLE on `flush_i`.
- Single-cycle ops and illegal codes: result computed combinationally and written to `result_o` at the accept edge.
- Multiply:
  - Load operand magnitudes (signedness per op; MULHSU treats `a` as signed and `b` as unsigned).
  - Run XLEN shift-add iterations into a 2·XLEN product.
  - Negate the product if the operand signs differ.
  - MUL returns the low half; the MULH* ops return the high half.
- Divide:
  - Restoring algorithm, XLEN iterations on magnitudes.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Quotient truncates toward zero.
- Divide fast paths (single cycle):
  - Divisor 0: quotient = all ones, remainder = dividend.
  - Signed overflow (most-negative ÷ −1): quotient = dividend, remainder = 0.
- Sign fix-up happens on the last iteration edge, not in an extra cycle.
- `valid_o` stays set and `result_o` stays stable until `valid_o && ready_i`.
- If `ready_i` is high and a new op is accepted in the same cycle, the new result or operation replaces the old one at that edge with no bubble.
- `flush_i` (priority over every other input):
  - Clears `valid_o` and returns the FSM to IDLE at the next edge.
  - Blocks acceptance in the cycle it is asserted.

## Timing

- Reset values: `valid_o` 0, `result_o` 0, `busy_o` 0, state IDLE, `ready_o` 1 (derived from state and `valid_o`).
- Asserting `res_i` mid-operation clears everything immediately; there is no partial result.
- Single-cycle ops, fast paths and illegal codes: accepted at edge k, `valid_o` high from edge k.
- MUL*/DIV*/REM*: accepted at edge k, iterations on edges k+1 … k+XLEN, `valid_o` high from edge k+XLEN. That is XLEN+1 cycles, counting the accept cycle.
- `busy_o` is high from edge k to edge k+XLEN; `ready_o` is low throughout.
- The iteration counter is SHW+1 bits, loaded with XLEN and decremented; completion is at 1→0.

## Structure

- Package `exec_pkg` holds:
  - Op-code localparams (`OP_ADD` … `OP_REMU`).
  - The state enum (`ST_IDLE`, `ST_MUL`, `ST_DIV`).
  - The helper function `is_iter_op`.
- Sub-module `alu_core`: a purely combinational single-cycle ALU parametrised by XLEN, instantiated once.
- The FSM, counter, product/remainder registers and handshake logic stay in `exec_unit`.

## Test plan

- ADD 7+5 → 12 one cycle after accept. SUB 0−1 → 0xFFFFFFFF. SRA 0x80000000 by 4 → 0xF8000000. SLTU 1 vs 0xFFFFFFFF → 1. Op 10 → 0.
- MUL and MULH of 0xFFFFFFFF × 2:
  - MUL → 0xFFFFFFFE, MULH → 0xFFFFFFFF, MULHU → 0x00000001.
  - `valid_o` exactly 33 cycles after accept; `ready_o` low and `busy_o` high meanwhile.
- Divide by zero, one cycle each: DIV 7/0 → 0xFFFFFFFF, REM 7/0 → 7.
- Signed overflow, one cycle each: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0.
- DIV −7/2 → 0xFFFFFFFD, REM → 0xFFFFFFFF. DIVU 100/7 → 14, REMU → 2. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Backpressure:
  - `ready_i` low for 5 cycles: `result_o` stable, `valid_o` high, `ready_o` low.
  - `ready_i` then rises together with `valid_i` (ADD 1+1): the new op is accepted and `result_o` = 2 the next cycle.
- `flush_i` during DIVU iteration 10: `valid_o` stays 0 and `ready_o` is 1 the following cycle. `res_i` low during MUL: `busy_o`/`valid_o` drop without waiting for a clock edge.
